// File: rtl/mcdf_pkg.sv
// rtl/mcdf_pkg.sv - shared types and constants for the MCDF formatter receive path
package mcdf_pkg;
    localparam int CHID_W = 2;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 6;

    // Packet lengths the formatter is allowed to announce
    localparam logic [LEN_W-1:0] LEN_4  = 6'd4;
    localparam logic [LEN_W-1:0] LEN_8  = 6'd8;
    localparam logic [LEN_W-1:0] LEN_16 = 6'd16;
    localparam logic [LEN_W-1:0] LEN_32 = 6'd32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_WAIT_START,
        ST_RECV,
        ST_DRAIN
    } rx_state_e;
endpackage

// File: rtl/fmt_rx_buf.sv
// rtl/fmt_rx_buf.sv - single packet word store, synchronous write, combinational read
module fmt_rx_buf
    import mcdf_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fmt_receiver.sv
// rtl/fmt_receiver.sv - grants the formatter, captures one framed packet, replays it downstream
module fmt_receiver
    import mcdf_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int START_TO = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fmt_req_i,
    output logic              fmt_grant_o,
    input  logic [CHID_W-1:0] fmt_chid_i,
    input  logic [LEN_W-1:0]  fmt_length_i,
    input  logic [DATA_W-1:0] fmt_data_i,
    input  logic              fmt_start_i,
    input  logic              fmt_end_i,
    output logic              rd_val_o,
    input  logic              rd_rdy_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [CHID_W-1:0] rd_chid_o,
    output logic              rd_last_o,
    output logic              len_err_o,
    output logic              frm_err_o,
    output logic              busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(START_TO + 1);
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    rx_state_e         state, state_nxt;
    logic [LEN_W-1:0]  wr_cnt, rd_cnt, len, size, wr_cnt_p1;
    logic [CHID_W-1:0] chid;
    logic [TW-1:0]     to_cnt;
    logic              len_err_q, frm_err_q, len_bad, drain, rd_last;
    logic              buf_we, cap_start, wr_inc, wr_clr, end_cap;
    logic              to_clr, to_inc, rd_inc, rd_done, len_set, frm_set;
    logic [AW-1:0]     buf_waddr;
    logic [DATA_W-1:0] buf_rdata;

    assign wr_cnt_p1 = wr_cnt + 1'b1;
    assign len_bad   = (fmt_length_i == '0) || (fmt_length_i > DEPTH_L);
    assign drain     = (state == ST_DRAIN);
    assign rd_last   = drain && (rd_cnt == size - 1'b1);
    assign buf_waddr = cap_start ? '0 : wr_cnt[AW-1:0];
    assign wr_clr    = (state != ST_IDLE) && (state_nxt == ST_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        buf_we    = 1'b0;
        cap_start = 1'b0;
        wr_inc    = 1'b0;
        end_cap   = 1'b0;
        to_clr    = 1'b0;
        to_inc    = 1'b0;
        rd_inc    = 1'b0;
        rd_done   = 1'b0;
        len_set   = 1'b0;
        frm_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fmt_req_i) state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                to_clr    = 1'b1;
                state_nxt = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (fmt_start_i && fmt_end_i) begin
                    frm_set   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (fmt_start_i) begin
                    cap_start = 1'b1;
                    buf_we    = 1'b1;
                    len_set   = len_bad;
                    state_nxt = ST_RECV;
                end else if (to_cnt == TW'(START_TO)) begin
                    frm_set   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    to_inc = 1'b1;
                end
            end
            ST_RECV: begin
                if (fmt_start_i) begin
                    // A new start mid-packet abandons the partial packet and recaptures
                    frm_set = 1'b1;
                    if (fmt_end_i) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        cap_start = 1'b1;
                        buf_we    = 1'b1;
                        len_set   = len_bad;
                    end
                end else begin
                    if (wr_cnt < DEPTH_L) begin
                        buf_we = 1'b1;
                        wr_inc = 1'b1;
                    end
                    if (fmt_end_i) begin
                        end_cap   = 1'b1;
                        len_set   = (wr_cnt < DEPTH_L) && (wr_cnt_p1 != len);
                        state_nxt = ST_DRAIN;
                    end else if (wr_cnt_p1 == DEPTH_L) begin
                        len_set = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (rd_rdy_i) begin
                    if (rd_last) begin
                        rd_done   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        rd_inc = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        fmt_grant_o = (state == ST_GRANT);
        rd_val_o    = drain;
        rd_data_o   = drain ? buf_rdata : '0;
        rd_chid_o   = drain ? chid : '0;
        rd_last_o   = rd_last;
        busy_o      = (state != ST_IDLE);
        len_err_o   = len_err_q;
        frm_err_o   = frm_err_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            len       <= '0;
            size      <= '0;
            chid      <= '0;
            to_cnt    <= '0;
            len_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            len_err_q <= len_set;
            frm_err_q <= frm_set;
            if (to_clr) begin
                to_cnt <= '0;
            end else if (to_inc) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (cap_start) begin
                chid   <= fmt_chid_i;
                len    <= len_bad ? DEPTH_L : fmt_length_i;
                wr_cnt <= 6'd1;
            end else if (wr_clr) begin
                wr_cnt <= '0;
            end else if (wr_inc) begin
                wr_cnt <= wr_cnt_p1;
            end
            // An overflowed packet stops counting at DEPTH, so it drains DEPTH words
            if (end_cap) begin
                size <= (wr_cnt < DEPTH_L) ? wr_cnt_p1 : DEPTH_L;
            end
            if (rd_done) begin
                rd_cnt <= '0;
            end else if (rd_inc) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    fmt_rx_buf #(.DEPTH(DEPTH)) u_buf (
        .clk   (clk_i),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (fmt_data_i),
        .raddr (rd_cnt[AW-1:0]),
        .rdata (buf_rdata)
    );
endmodule

// File: tb/tb_fmt_receiver.sv
// tb/tb_fmt_receiver.sv - scoreboard bench for fmt_receiver
module tb_fmt_receiver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        grant;
    logic [1:0]  chid_in = '0;
    logic [5:0]  len_in = '0;
    logic [31:0] data_in = '0;
    logic        start_in = 1'b0;
    logic        end_in = 1'b0;
    logic        rd_val;
    logic        rd_rdy = 1'b1;
    logic [31:0] rd_data;
    logic [1:0]  rd_chid;
    logic        rd_last;
    logic        len_err;
    logic        frm_err;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int len_cnt = 0;
    int frm_cnt = 0;
    int grant_cnt = 0;
    logic [34:0] sb[$];
    logic        hold_v = 1'b0;
    logic [31:0] hold_d = '0;

    fmt_receiver dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .fmt_req_i    (req),
        .fmt_grant_o  (grant),
        .fmt_chid_i   (chid_in),
        .fmt_length_i (len_in),
        .fmt_data_i   (data_in),
        .fmt_start_i  (start_in),
        .fmt_end_i    (end_in),
        .rd_val_o     (rd_val),
        .rd_rdy_i     (rd_rdy),
        .rd_data_o    (rd_data),
        .rd_chid_o    (rd_chid),
        .rd_last_o    (rd_last),
        .len_err_o    (len_err),
        .frm_err_o    (frm_err),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (len_err) len_cnt++;
        if (frm_err) frm_cnt++;
        if (grant) grant_cnt++;
        if (rd_val && hold_v) chk("hold_data", rd_data, hold_d);
        if (rd_val && rd_rdy) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_word observed=%0h expected=none", rd_data);
            end
            if (sb.size() != 0) begin
                logic [34:0] e;
                e = sb.pop_front();
                chk("rd_data", rd_data, e[31:0]);
                chk("rd_chid", 32'(rd_chid), 32'(e[33:32]));
                chk("rd_last", 32'(rd_last), 32'(e[34]));
            end
        end
        hold_v = rd_val && !rd_rdy && !rst;
        hold_d = rd_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request();
        req = 1'b1;
        tick();
        chk("grant_latency", 32'(grant), 32'd1);
        req = 1'b0;
        tick();
        chk("grant_single", 32'(grant), 32'd0);
    endtask

    task automatic drive_packet(input logic [1:0] c, input logic [5:0] l, input int n,
                                input logic [31:0] base, input logic [31:0] step,
                                input bit push, input bit do_end);
        for (int i = 0; i < n; i++) begin
            start_in = (i == 0);
            end_in   = do_end && (i == n - 1);
            chid_in  = c;
            len_in   = l;
            data_in  = base + step * 32'(i);
            if (push) sb.push_back({end_in, c, data_in});
            tick();
        end
        start_in = 1'b0;
        end_in   = 1'b0;
        data_in  = '0;
    endtask

    task automatic drain(input bit toggle);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            if (toggle) rd_rdy = ~rd_rdy;
            tick();
            n++;
        end
        chk("drain_done", 32'(sb.size()), 32'd0);
        rd_rdy = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_rd_val"}, 32'(rd_val), 32'd0);
        chk({tag, "_rd_data"}, rd_data, 32'd0);
        chk({tag, "_rd_chid"}, 32'(rd_chid), 32'd0);
        chk({tag, "_rd_last"}, 32'(rd_last), 32'd0);
        chk({tag, "_len_err"}, 32'(len_err), 32'd0);
        chk({tag, "_frm_err"}, 32'(frm_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int l0, f0, g0;
        rst = 1'b1;
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Length-4 packet, always ready
        l0 = len_cnt; f0 = frm_cnt;
        request();
        chk("wait_rd_val", 32'(rd_val), 32'd0);
        drive_packet(2'd2, 6'd4, 4, 32'h11, 32'h11, 1, 1);
        chk("drain_latency", 32'(rd_val), 32'd1);
        chk("first_word", rd_data, 32'h11);
        drain(0);
        chk("p1_busy", 32'(busy), 32'd0);
        chk("p1_len_err", 32'(len_cnt - l0), 32'd0);
        chk("p1_frm_err", 32'(frm_cnt - f0), 32'd0);

        // Length-32 packet with stalling consumer; request held during replay
        request();
        drive_packet(2'd1, 6'd32, 32, 32'h1000, 32'h3, 1, 1);
        req = 1'b1;
        g0 = grant_cnt;
        drain(1);
        chk("no_grant_in_drain", 32'(grant_cnt - g0), 32'd0);
        chk("p2_busy", 32'(busy), 32'd0);
        tick();
        chk("regrant", 32'(grant), 32'd1);
        req = 1'b0;
        tick();
        chk("regrant_single", 32'(grant), 32'd0);

        // Announced 8 words, end on the 6th
        l0 = len_cnt; f0 = frm_cnt;
        drive_packet(2'd1, 6'd8, 6, 32'h600, 32'h1, 1, 1);
        chk("short_len_err", 32'(len_err), 32'd1);
        drain(0);
        chk("p3_len_err", 32'(len_cnt - l0), 32'd1);
        chk("p3_frm_err", 32'(frm_cnt - f0), 32'd0);

        // Start timeout
        request();
        repeat (15) tick();
        chk("to_early_frm", 32'(frm_err), 32'd0);
        chk("to_early_busy", 32'(busy), 32'd1);
        tick();
        chk("to_frm_err", 32'(frm_err), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        tick();
        chk("to_frm_single", 32'(frm_err), 32'd0);

        // Reset in the middle of a 16-word capture
        request();
        drive_packet(2'd0, 6'd16, 3, 32'hDEAD0000, 32'h1, 0, 0);
        rst = 1'b1;
        tick();
        check_idle_outputs("mid_reset");
        rst = 1'b0;
        l0 = len_cnt; f0 = frm_cnt;
        request();
        drive_packet(2'd3, 6'd4, 4, 32'hA0, 32'h1, 1, 1);
        drain(0);
        chk("p5_len_err", 32'(len_cnt - l0), 32'd0);
        chk("p5_frm_err", 32'(frm_cnt - f0), 32'd0);

        // Restart on a start at word 5 of 16
        l0 = len_cnt; f0 = frm_cnt;
        request();
        drive_packet(2'd0, 6'd16, 5, 32'hB00, 32'h1, 0, 0);
        drive_packet(2'd1, 6'd16, 16, 32'hC00, 32'h5, 1, 1);
        drain(0);
        chk("p6_frm_err", 32'(frm_cnt - f0), 32'd1);
        chk("p6_len_err", 32'(len_cnt - l0), 32'd0);

        // Length field 0 is taken as full depth
        l0 = len_cnt; f0 = frm_cnt;
        request();
        drive_packet(2'd2, 6'd0, 32, 32'hD00, 32'h7, 1, 1);
        drain(0);
        chk("p7_len_err", 32'(len_cnt - l0), 32'd1);
        chk("p7_frm_err", 32'(frm_cnt - f0), 32'd0);
        chk("p7_busy", 32'(busy), 32'd0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
